// File: rtl/player_anim_ctrl.sv
// Player sprite animation sequencer.
// Chooses the bitmap frame and horizontal mirroring once per VGA frame, and
// blinks the sprite after a hit. The offset/inside remap into the bitmap ROM
// is purely combinational, so it adds no latency to the pixel path.
module player_anim_ctrl #(
    parameter int OBJECT_WIDTH_X  = 20,
    parameter int FRAMES_PER_STEP = 6,
    parameter int SHOOT_FRAMES    = 10,
    parameter int BLINK_FRAMES    = 90,
    parameter int BLINK_PERIOD    = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        moveLeft,
    input  logic        moveRight,
    input  logic        shootReq,
    input  logic        hitPulse,
    input  logic [10:0] offsetXIn,
    input  logic        insideIn,
    output logic [10:0] offsetXOut,
    output logic        insideOut,
    output logic [1:0]  frameIdx,
    output logic        mirrorX,
    output logic        shootBusy,
    output logic        blinking
);

    // Counter widths; a parameter of 1 would give $clog2 = 0, so floor at 1 bit.
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HW = (SHOOT_FRAMES > 1) ? $clog2(SHOOT_FRAMES) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int PB = $clog2(BLINK_PERIOD) - 1;

    localparam logic [SW-1:0] STEP_LAST  = SW'(FRAMES_PER_STEP - 1);
    localparam logic [HW-1:0] SHOOT_LAST = HW'(SHOOT_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);
    localparam logic [10:0]   X_LAST     = 11'(OBJECT_WIDTH_X - 1);

    typedef enum logic [1:0] {IDLE, WALK, SHOOT} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] step_cnt, step_nxt;
    logic          walk_phase, phase_nxt;
    logic [HW-1:0] shoot_cnt, shoot_nxt;
    logic [BW-1:0] blink_cnt, blink_nxt;
    logic [1:0]    frame_nxt;
    logic          mirror_nxt, busy_nxt;
    logic          move_one, hidden;

    assign move_one = moveLeft ^ moveRight;

    // State and registered outputs; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            step_cnt   <= '0;
            walk_phase <= 1'b0;
            shoot_cnt  <= '0;
            blink_cnt  <= '0;
            frameIdx   <= 2'd0;
            mirrorX    <= 1'b0;
            shootBusy  <= 1'b0;
            blinking   <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_cnt   <= step_nxt;
            walk_phase <= phase_nxt;
            shoot_cnt  <= shoot_nxt;
            blink_cnt  <= blink_nxt;
            frameIdx   <= frame_nxt;
            mirrorX    <= mirror_nxt;
            shootBusy  <= busy_nxt;
            blinking   <= (blink_nxt != '0);
        end
    end

    // Next-state logic; only a start-of-frame cycle may change the pose.
    always_comb begin
        state_nxt  = state;
        step_nxt   = step_cnt;
        phase_nxt  = walk_phase;
        shoot_nxt  = shoot_cnt;
        frame_nxt  = frameIdx;
        mirror_nxt = mirrorX;
        busy_nxt   = shootBusy;
        if (startOfFrame) begin
            case (state)
                IDLE: begin
                    if (shootReq) begin
                        state_nxt = SHOOT;
                        shoot_nxt = SHOOT_LAST;
                        frame_nxt = 2'd3;
                        busy_nxt  = 1'b1;
                    end else if (move_one) begin
                        state_nxt  = WALK;
                        mirror_nxt = moveLeft;
                        step_nxt   = '0;
                        phase_nxt  = 1'b0;
                        frame_nxt  = 2'd1;
                    end else begin
                        frame_nxt = 2'd0;
                    end
                end
                WALK: begin
                    if (shootReq) begin
                        state_nxt = SHOOT;
                        shoot_nxt = SHOOT_LAST;
                        frame_nxt = 2'd3;
                        busy_nxt  = 1'b1;
                    end else if (!move_one) begin
                        state_nxt = IDLE;
                        frame_nxt = 2'd0;
                    end else if (moveLeft != mirrorX) begin
                        // Reversal restarts the walk cycle facing the new way.
                        mirror_nxt = moveLeft;
                        step_nxt   = '0;
                        phase_nxt  = 1'b0;
                        frame_nxt  = 2'd1;
                    end else if (step_cnt == STEP_LAST) begin
                        step_nxt  = '0;
                        phase_nxt = ~walk_phase;
                        frame_nxt = walk_phase ? 2'd1 : 2'd2;
                    end else begin
                        step_nxt  = step_cnt + SW'(1);
                        frame_nxt = walk_phase ? 2'd2 : 2'd1;
                    end
                end
                SHOOT: begin
                    if (shoot_cnt == '0) begin
                        state_nxt = IDLE;
                        frame_nxt = 2'd0;
                        busy_nxt  = 1'b0;
                    end else begin
                        shoot_nxt = shoot_cnt - HW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    frame_nxt = 2'd0;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Blink countdown; a hit on any cycle reloads it and beats the decrement.
    always_comb begin
        blink_nxt = blink_cnt;
        if (hitPulse)
            blink_nxt = BLINK_LOAD;
        else if (startOfFrame && blink_cnt != '0)
            blink_nxt = blink_cnt - BW'(1);
    end

    // Pixel-path remap: mirror inside the sprite only, so no underflow outside it.
    assign hidden     = blinking & blink_cnt[PB];
    assign insideOut  = insideIn & ~hidden;
    assign offsetXOut = (mirrorX & insideIn) ? (X_LAST - offsetXIn) : offsetXIn;

endmodule
